// File: rtl/fft_stage_collector.sv
// fft_stage_collector
// Collects one FFT stage's butterfly outputs, arriving as (A,B) pairs in the
// butterfly index-pairing order, scatters them into a local buffer and then
// drains the buffer in natural index order.
//
// Handshake: a transfer happens on any rising edge where valid && ready. A
// source holds valid and its payload until that edge, and ready never waits
// on valid. in_ready is high except while draining. out_valid is high
// throughout the drain. Payload is held stable while out_ready is low.
module fft_stage_collector #(
    parameter int SAMPLES = 8,
    parameter int WIDTH   = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [$clog2(SAMPLES)-1:0] stage,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_a,
    input  logic [WIDTH-1:0]           in_b,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(SAMPLES)-1:0] out_index,
    output logic                       out_last,
    output logic                       busy,
    output logic                       stage_err
);

    localparam int LOG2  = $clog2(SAMPLES);
    localparam int NPAIR = SAMPLES / 2;

    localparam logic [LOG2-1:0] ONE    = LOG2'(1);
    localparam logic [LOG2-1:0] LAST_P = LOG2'(NPAIR - 1);
    localparam logic [LOG2-1:0] LAST_R = LOG2'(SAMPLES - 1);
    localparam logic [LOG2:0]   LOG2_W = (LOG2 + 1)'(LOG2);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_DRAIN   = 2'd2;

    logic [1:0]       state;
    logic [LOG2-1:0]  p;
    logic [LOG2-1:0]  r;
    logic [LOG2-1:0]  s_reg;
    logic [WIDTH-1:0] mem [SAMPLES];

    logic            in_xfer;
    logic            out_xfer;
    logic [LOG2-1:0] cur_s;
    logic            legal;
    logic [LOG2-1:0] span;
    logic [LOG2-1:0] j;
    logic [LOG2-1:0] g;
    logic [LOG2:0]   sh1;
    logic [LOG2-1:0] addr_a;
    logic [LOG2-1:0] addr_b;

    assign in_ready  = (state != ST_DRAIN);
    assign out_valid = (state == ST_DRAIN);
    assign busy      = (state != ST_IDLE);
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;

    assign out_data  = out_valid ? mem[r] : '0;
    assign out_index = out_valid ? r : '0;
    assign out_last  = out_valid && (r == LAST_R);

    // Scatter addresses for the current pair; the first pair of a frame uses
    // the live stage input because s_reg is only loaded on that same edge.
    always_comb begin
        cur_s  = (state == ST_IDLE) ? stage : s_reg;
        legal  = ({1'b0, cur_s} < LOG2_W);
        span   = ONE << cur_s;
        j      = p & (span - ONE);
        g      = p >> cur_s;
        sh1    = {1'b0, cur_s} + (LOG2 + 1)'(1);
        addr_a = (g << sh1) + j;
        addr_b = addr_a + span;
    end

    // Frame sequencing: pair counter, drain pointer, stage capture, error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            p         <= '0;
            r         <= '0;
            s_reg     <= '0;
            stage_err <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_COLLECT: begin
                    if (in_xfer) begin
                        if (state == ST_IDLE) begin
                            s_reg <= stage;
                            if (!legal) stage_err <= 1'b1;
                        end
                        if (p == LAST_P) begin
                            p     <= '0;
                            state <= ST_DRAIN;
                        end else begin
                            p     <= p + ONE;
                            state <= ST_COLLECT;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (out_xfer) begin
                        if (r == LAST_R) begin
                            r     <= '0;
                            state <= ST_IDLE;
                        end else begin
                            r <= r + ONE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Buffer writes: both halves of a pair in its transfer cycle, skipped for
    // an illegal stage so the previous frame's contents survive.
    always_ff @(posedge clk) begin
        if (!reset && in_xfer && legal) begin
            mem[addr_a] <= in_a;
            mem[addr_b] <= in_b;
        end
    end

endmodule

// File: tb/tb_fft_stage_collector.sv
// tb_fft_stage_collector
// Drives frames of butterfly pairs for SAMPLES=8 and checks the drained words
// against a buffer model built from the stage's block/offset structure.
module tb_fft_stage_collector;

    localparam int SAMPLES = 8;
    localparam int WIDTH   = 16;
    localparam int LOG2    = 3;
    localparam int NPAIR   = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [LOG2-1:0]  stage;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [LOG2-1:0]  out_index;
    logic             out_last;
    logic             busy;
    logic             stage_err;

    int errors = 0;
    int checks = 0;

    logic [WIDTH-1:0] model_mem [SAMPLES];
    logic             model_err;
    logic [WIDTH-1:0] exp_q [$];

    fft_stage_collector #(.SAMPLES(SAMPLES), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .stage     (stage),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .out_last  (out_last),
        .busy      (busy),
        .stage_err (stage_err)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_in_ready"},  32'(in_ready),  32'd1);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_busy"},      32'(busy),      32'd0);
        check({tag, "_out_data"},  32'(out_data),  32'd0);
        check({tag, "_out_index"}, 32'(out_index), 32'd0);
        check({tag, "_out_last"},  32'(out_last),  32'd0);
    endtask

    // Reset pulse: entered and left at a negedge; in_valid may be held high to
    // show that a pair offered alongside reset is dropped.
    task automatic do_reset(input bit with_pair);
        reset    = 1'b1;
        in_valid = with_pair;
        in_a     = WIDTH'($urandom);
        in_b     = WIDTH'($urandom);
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        model_err = 1'b0;
        check_idle("reset");
        check("reset_stage_err", 32'(stage_err), 32'd0);
    endtask

    // Sends npairs pairs of a frame at stage s. The model places pair p at the
    // p-th upper index obtained by walking blocks of 2^(s+1) points and the
    // first 2^s offsets inside each; the lower partner is 2^s further on.
    task automatic send_frame(input int s, input bit fixed, input bit gaps, input int npairs);
        int a_list [$];
        logic [WIDTH-1:0] va, vb;
        if (s < LOG2) begin
            for (int base = 0; base < SAMPLES; base += (2 << s))
                for (int k = 0; k < (1 << s); k++)
                    a_list.push_back(base + k);
        end
        for (int p = 0; p < npairs; p++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    in_valid = 1'b0;
                    check("gap_in_ready",  32'(in_ready),  32'd1);
                    check("gap_out_valid", 32'(out_valid), 32'd0);
                    check("gap_busy",      32'(busy),      32'(p != 0));
                    @(negedge clk);
                end
            end
            check("col_in_ready",  32'(in_ready),  32'd1);
            check("col_out_valid", 32'(out_valid), 32'd0);
            check("col_busy",      32'(busy),      32'(p != 0));
            if (p != 0) check("col_stage_err", 32'(stage_err), 32'(model_err));
            va = fixed ? WIDTH'(100 + p) : WIDTH'($urandom);
            vb = fixed ? WIDTH'(200 + p) : WIDTH'($urandom);
            in_valid = 1'b1;
            in_a     = va;
            in_b     = vb;
            stage    = (p == 0) ? LOG2'(s) : LOG2'($urandom_range(0, 7));
            @(negedge clk);
            if (s < LOG2) begin
                model_mem[a_list[p]]            = va;
                model_mem[a_list[p] + (1 << s)] = vb;
            end
            if (p == 0 && s >= LOG2) model_err = 1'b1;
        end
        in_valid = 1'b0;
        stage    = LOG2'($urandom_range(0, 7));
        check("end_stage_err", 32'(stage_err), 32'(model_err));
    endtask

    // Drains one frame; entered at the first negedge after the last pair.
    task automatic drain(input bit stall);
        int cnt = 0;
        int cyc = 0;
        bit rdy;
        exp_q.delete();
        for (int i = 0; i < SAMPLES; i++) exp_q.push_back(model_mem[i]);
        while (exp_q.size() > 0 && cyc < 200) begin
            check("drn_out_valid", 32'(out_valid), 32'd1);
            check("drn_out_index", 32'(out_index), 32'(cnt));
            check("drn_out_data",  32'(out_data),  32'(exp_q[0]));
            check("drn_out_last",  32'(out_last),  32'(cnt == SAMPLES - 1));
            check("drn_in_ready",  32'(in_ready),  32'd0);
            check("drn_busy",      32'(busy),      32'd1);
            check("drn_stage_err", 32'(stage_err), 32'(model_err));
            rdy       = stall ? (cyc % 3 == 0) : 1'b1;
            out_ready = rdy;
            in_valid  = stall ? 1'($urandom_range(0, 1)) : 1'b0;
            in_a      = WIDTH'($urandom);
            in_b      = WIDTH'($urandom);
            @(negedge clk);
            cyc++;
            if (rdy) begin
                void'(exp_q.pop_front());
                cnt++;
            end
        end
        check("drain_words_left", 32'(exp_q.size()), 32'd0);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check_idle("post_drain");
    endtask

    initial begin
        reset     = 1'b1;
        stage     = '0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        model_err = 1'b0;
        for (int i = 0; i < SAMPLES; i++) model_mem[i] = '0;
        @(negedge clk);
        do_reset(1'b0);

        // Directed frames with fixed data
        send_frame(0, 1'b1, 1'b0, NPAIR); drain(1'b0);
        send_frame(1, 1'b1, 1'b0, NPAIR); drain(1'b0);
        send_frame(2, 1'b1, 1'b0, NPAIR); drain(1'b0);
        send_frame(1, 1'b1, 1'b1, NPAIR); drain(1'b1);

        // Random frames
        for (int f = 0; f < 6; f++) begin
            send_frame($urandom_range(0, 2), 1'b0, 1'($urandom_range(0, 1)), NPAIR);
            drain(1'($urandom_range(0, 1)));
        end

        // Abort after two pairs, with a pair offered alongside reset
        send_frame(2, 1'b0, 1'b0, 2);
        do_reset(1'b1);
        repeat (3) begin
            check("abort_no_drain", 32'(out_valid), 32'd0);
            @(negedge clk);
        end
        send_frame(0, 1'b1, 1'b0, NPAIR); drain(1'b0);

        // Illegal stage: pairs accepted, buffer untouched, flag sticky
        send_frame(3, 1'b0, 1'b1, NPAIR); drain(1'b1);
        repeat (2) @(negedge clk);
        check("err_sticky", 32'(stage_err), 32'd1);
        send_frame(1, 1'b0, 1'b0, NPAIR); drain(1'b0);
        check("err_sticky_after_legal", 32'(stage_err), 32'd1);
        do_reset(1'b0);

        // Reset in the middle of a drain, then recover
        send_frame(1, 1'b0, 1'b0, NPAIR);
        repeat (3) begin
            out_ready = 1'b0;
            check("mid_drain_valid", 32'(out_valid), 32'd1);
            @(negedge clk);
        end
        do_reset(1'b0);
        send_frame(2, 1'b0, 1'b1, NPAIR); drain(1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
